decode_ctrl: RTL and testbench
==============================

DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the width of the program counter and start address.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the retired-instruction counter.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Go, input, 1 bit: one-cycle pulse that launches a program.
REQ-006 SHALL have port ProgAddr, input, ADDR_W bits: program start address.
REQ-007 SHALL have port InstrOut, input, 9 bits: instruction from InstrROM at the current PC.
REQ-008 SHALL have port AluZero, input, 1 bit: ALU result-is-zero for the ALU op issued this cycle.
REQ-009 SHALL have outputs Start (1), Start_Addr (ADDR_W), Branch (1), Zero (1) and Offset (6), all driving IF.
REQ-010 SHALL have outputs Opcode (3), RegSel (3), Imm (3), RegWrite (1), MemRead (1) and MemWrite (1), all driving the datapath.
REQ-011 SHALL have outputs Done (1) and InstrCount (CNT_W).

Function
REQ-012 SHALL decode the 9-bit instruction as: [8:6] opcode, [5:3] RegSel, [2:0] Imm, [5:0] Offset (signed two's complement).
REQ-013 SHALL use this opcode map: 000 ADD, 001 SUB, 010 AND, 011 LOAD, 100 STORE, 101 LI, 110 BZ, 111 SYS.
REQ-014 SHALL treat SYS with [5:0]=6'h3F as HALT and any other SYS encoding as NOP.
REQ-015 SHALL implement FSM states IDLE, RUN and HALTED.
REQ-016 SHALL drive Start=1 and Start_Addr=ProgAddr in IDLE and HALTED, which holds the IF PC at ProgAddr.
REQ-017 SHALL transition to RUN on Go in IDLE or HALTED, and SHALL ignore Go while in RUN.
REQ-018 SHALL drive Start=0 in RUN.
REQ-019 SHALL capture InstrOut into instruction register IR, with a valid bit IV, on every RUN cycle.
REQ-020 SHALL clear IV on the first RUN cycle after entry, giving a one-cycle fill latency.
REQ-021 SHALL take all decode outputs combinationally from IR, and SHALL force them to 0 unless IV=1 and state is RUN.
REQ-022 SHALL assert RegWrite for ADD, SUB, AND, LOAD and LI; MemRead for LOAD; and MemWrite for STORE.
REQ-023 SHALL load the registered Zero flag from AluZero at the clock edge only for a valid ADD, SUB or AND; all other ops hold it.
REQ-024 SHALL assert Branch for a valid BZ; IF then applies Offset to its current PC (BZ address + 1) when Zero=1.
REQ-025 SHALL, on a taken branch (Branch and Zero both 1), clear IV at the next edge, squashing the wrong-path instruction.
REQ-026 SHALL, on a not-taken BZ, flush nothing.
REQ-027 SHALL, on a valid HALT, enter HALTED at the next edge and clear IV.
REQ-028 SHALL hold Done=1 in HALTED until Go or Reset.
REQ-029 SHALL increment InstrCount on each valid retired instruction (including BZ and HALT, excluding squashed slots).
REQ-030 SHALL wrap InstrCount modulo 2^CNT_W.
REQ-031 SHALL clear InstrCount and Zero when Go is accepted.
REQ-032 SHALL, when Go and Reset are asserted together, give Reset priority.

Reset
REQ-033 SHALL, when Reset=1, set state=IDLE, IR=0, IV=0, Zero=0, InstrCount=0 and Done=0 at the next edge.
REQ-034 SHALL, after reset, drive Start=1, Start_Addr=ProgAddr and all control outputs 0.
REQ-035 SHALL, on Reset mid-program, abandon the program with no partial retire.

Structure
REQ-036 SHALL place the opcode enum (op_t), the HALT encoding constant and the field-position constants in shared package isa_pkg.
REQ-037 SHALL be a single module; the combinational decoder MAY be sub-module instr_decoder, from IR to control outputs.

Verification
REQ-038 SHALL cover Reset then Go with ProgAddr=8'd10: PC 10,11,12..., IV low for one cycle, first decoded instruction = ROM[10].
REQ-039 SHALL cover SUB with AluZero=1 then BZ with Offset=+4 at address 20: Branch=1 and Zero=1; the address-21 instruction is squashed (InstrCount unchanged); next valid IR = ROM[25].
REQ-040 SHALL cover BZ with Zero=0: no flush; next IR = ROM[BZ+1].
REQ-041 SHALL cover Offset=-5 (6'h3B) taken from address 30: next valid IR = ROM[26].
REQ-042 SHALL cover HALT (9'h1FF) after 7 instructions: Done=1, InstrCount=8, Start=1; a subsequent Go restarts with InstrCount=0.
REQ-043 SHALL cover Reset asserted mid-RUN together with Go: state=IDLE, all outputs at reset values next cycle.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 9-bit instruction set: field positions,
// opcode map, HALT encoding and the decoded-control bundle.
package isa_pkg;

   localparam int INSTR_W   = 9;
   localparam int OPCODE_HI = 8;
   localparam int OPCODE_LO = 6;
   localparam int REGSEL_HI = 5;
   localparam int REGSEL_LO = 3;
   localparam int IMM_HI    = 2;
   localparam int IMM_LO    = 0;
   localparam int OFFSET_HI = 5;
   localparam int OFFSET_LO = 0;

   typedef enum logic [2:0] {
      OP_ADD   = 3'b000,
      OP_SUB   = 3'b001,
      OP_AND   = 3'b010,
      OP_LOAD  = 3'b011,
      OP_STORE = 3'b100,
      OP_LI    = 3'b101,
      OP_BZ    = 3'b110,
      OP_SYS   = 3'b111
   } op_t;

   // SYS with an all-ones function field halts; every other SYS is a NOP.
   localparam logic [5:0]         HALT_FUNC  = 6'h3F;
   localparam logic [INSTR_W-1:0] HALT_INSTR = {OP_SYS, HALT_FUNC};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic [2:0] opcode;
      logic [2:0] reg_sel;
      logic [2:0] imm;
      logic [5:0] offset;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       is_alu;
      logic       is_halt;
   } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decoder from the instruction register to the control bundle;
// every output is held at zero while the slot is not valid.
module instr_decoder
   import isa_pkg::*;
(
   input  logic [INSTR_W-1:0] ir,
   input  logic               valid,
   output dec_t               dec
);

   op_t op;

   always_comb begin
      // NOTE: every output gets a default before any branch so no latch is inferred.
      dec = '0;
      op  = op_t'(ir[OPCODE_HI:OPCODE_LO]);
      if (valid) begin
         dec.opcode  = ir[OPCODE_HI:OPCODE_LO];
         dec.reg_sel = ir[REGSEL_HI:REGSEL_LO];
         dec.imm     = ir[IMM_HI:IMM_LO];
         dec.offset  = ir[OFFSET_HI:OFFSET_LO];
         case (op)
            OP_ADD, OP_SUB, OP_AND: begin
               dec.reg_write = 1'b1;
               dec.is_alu    = 1'b1;
            end
            OP_LOAD: begin
               dec.reg_write = 1'b1;
               dec.mem_read  = 1'b1;
            end
            OP_STORE: dec.mem_write = 1'b1;
            OP_LI:    dec.reg_write = 1'b1;
            OP_BZ:    dec.branch    = 1'b1;
            OP_SYS:   dec.is_halt   = (ir == HALT_INSTR);
            default:  dec.is_halt   = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/decode_ctrl.sv
// Decode/control stage: launches programs into IF, registers the fetched
// instruction, squashes wrong-path slots after taken branches and counts retires.
module decode_ctrl
   import isa_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               Go,
   input  logic [ADDR_W-1:0]  ProgAddr,
   input  logic [INSTR_W-1:0] InstrOut,
   input  logic               AluZero,
   output logic               Start,
   output logic [ADDR_W-1:0]  Start_Addr,
   output logic               Branch,
   output logic               Zero,
   output logic [5:0]         Offset,
   output logic [2:0]         Opcode,
   output logic [2:0]         RegSel,
   output logic [2:0]         Imm,
   output logic               RegWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               Done,
   output logic [CNT_W-1:0]   InstrCount
);

   ctrl_state_t        state;
   logic [INSTR_W-1:0] ir;
   logic               iv;
   logic               zero_q;
   logic               start_q;
   logic               done_q;
   logic [CNT_W-1:0]   instr_cnt;
   logic               slot_valid;
   logic               taken;
   dec_t               dec;

   assign slot_valid = iv && (state == RUN);

   instr_decoder u_decoder (
      .ir    (ir),
      .valid (slot_valid),
      .dec   (dec)
   );

   // IF redirects on this same cycle, so the instruction it fetched meanwhile is wrong-path.
   assign taken = dec.branch && zero_q;

   always_ff @(posedge CLK) begin
      // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
      if (Reset) begin
         state     <= IDLE;
         ir        <= '0;
         iv        <= 1'b0;
         zero_q    <= 1'b0;
         instr_cnt <= '0;
         done_q    <= 1'b0;
         start_q   <= 1'b1;
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (Go) begin
                  state     <= RUN;
                  iv        <= 1'b0;
                  zero_q    <= 1'b0;
                  instr_cnt <= '0;
                  done_q    <= 1'b0;
                  start_q   <= 1'b0;
               end
            end
            RUN: begin
               ir <= InstrOut;
               iv <= !(taken || dec.is_halt);
               if (slot_valid) begin
                  instr_cnt <= instr_cnt + 1'b1;
               end
               if (dec.is_alu) begin
                  zero_q <= AluZero;
               end
               if (dec.is_halt) begin
                  state   <= HALTED;
                  done_q  <= 1'b1;
                  start_q <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               iv      <= 1'b0;
               start_q <= 1'b1;
            end
         endcase
      end
   end

   assign Start      = start_q;
   assign Start_Addr = ProgAddr;
   assign Zero       = zero_q;
   assign Done       = done_q;
   assign InstrCount = instr_cnt;

   assign Branch     = dec.branch;
   assign Offset     = dec.offset;
   assign Opcode     = dec.opcode;
   assign RegSel     = dec.reg_sel;
   assign Imm        = dec.imm;
   assign RegWrite   = dec.reg_write;
   assign MemRead    = dec.mem_read;
   assign MemWrite   = dec.mem_write;

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: an ISA-level interpreter predicts the retired instruction
// stream into a scoreboard; a monitor compares each decoded slot the DUT presents.
module tb_decode_ctrl;

   localparam int ADDR_W     = 8;
   localparam int CNT_W      = 4;
   localparam int MAX_STEPS  = 120;
   localparam int RAND_LEN   = 30;
   localparam int RUN_BUDGET = 400;
   localparam logic [8:0] HALT_WORD = 9'h1FF;

   logic              CLK = 1'b0;
   logic              Reset;
   logic              Go;
   logic [ADDR_W-1:0] ProgAddr;
   logic [8:0]        InstrOut;
   logic              AluZero;
   logic              Start;
   logic [ADDR_W-1:0] Start_Addr;
   logic              Branch;
   logic              Zero;
   logic [5:0]        Offset;
   logic [2:0]        Opcode;
   logic [2:0]        RegSel;
   logic [2:0]        Imm;
   logic              RegWrite;
   logic              MemRead;
   logic              MemWrite;
   logic              Done;
   logic [CNT_W-1:0]  InstrCount;

   always #5 CLK = ~CLK;

   decode_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .Go         (Go),
      .ProgAddr   (ProgAddr),
      .InstrOut   (InstrOut),
      .AluZero    (AluZero),
      .Start      (Start),
      .Start_Addr (Start_Addr),
      .Branch     (Branch),
      .Zero       (Zero),
      .Offset     (Offset),
      .Opcode     (Opcode),
      .RegSel     (RegSel),
      .Imm        (Imm),
      .RegWrite   (RegWrite),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Done       (Done),
      .InstrCount (InstrCount)
   );

   typedef struct {
      logic [8:0] instr;
      bit         zero;
      int         count;
      int         slot;
   } exp_t;

   logic [8:0] rom [256];
   logic [7:0] pc;
   logic       alu_noise = 1'b0;
   logic       dec_active;
   int         cyc = 0;
   int         go_cyc = 0;
   int         checks = 0;
   int         failures = 0;
   int         final_count = 0;
   bit         final_zero = 1'b0;
   exp_t       sb[$];
   exp_t       e;

   // Environment: IF stage (PC + instruction ROM) and an ALU whose zero flag
   // is the parity of the operand fields; other cycles see random noise.
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (Start)               pc <= Start_Addr;
      else if (Branch && Zero) pc <= pc + {{2{Offset[5]}}, Offset};
      else                     pc <= pc + 8'd1;
   end

   assign InstrOut   = rom[pc];
   assign AluZero    = (RegWrite && (Opcode <= 3'd2)) ? ^{RegSel, Imm} : alu_noise;
   assign dec_active = RegWrite | MemRead | MemWrite | Branch |
                       (|Opcode) | (|RegSel) | (|Imm) | (|Offset);

   initial begin
      forever begin
         @(posedge CLK);
         #2 alu_noise = 1'($urandom_range(1));
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] exp_ctrl(input logic [8:0] instr);
      int op;
      op = int'(instr[8:6]);
      // {RegWrite, MemRead, MemWrite, Branch}
      return {(op == 0 || op == 1 || op == 2 || op == 3 || op == 5), (op == 3), (op == 4), (op == 6)};
   endfunction

   // Scoreboard monitor: every slot that shows a decoded instruction retires one entry.
   always @(negedge CLK) begin
      if (dec_active) begin
         check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("opcode", 32'(Opcode), 32'(e.instr[8:6]));
            check("regsel", 32'(RegSel), 32'(e.instr[5:3]));
            check("imm",    32'(Imm),    32'(e.instr[2:0]));
            check("offset", 32'(Offset), 32'(e.instr[5:0]));
            check("ctrl",   32'({RegWrite, MemRead, MemWrite, Branch}), 32'(exp_ctrl(e.instr)));
            check("zero",   32'(Zero), 32'(e.zero));
            check("count",  32'(InstrCount), 32'(e.count % (1 << CNT_W)));
            check("slot",   32'(cyc - go_cyc), 32'(e.slot));
         end
      end
   end

   // ISA-level interpreter: walks the program from start, queueing each retired
   // instruction with the Zero flag, retire count and cycle slot it should show.
   task automatic model_run(input logic [7:0] start, input int patch_after, output bit halted);
      logic [7:0] mpc;
      bit         z;
      int         cnt;
      int         slot;
      int         op;
      int         off;
      bit         visited [256];
      logic [8:0] ins;
      mpc    = start;
      z      = 1'b0;
      cnt    = 0;
      slot   = 1;
      halted = 1'b0;
      for (int i = 0; i < 256; i++) visited[i] = 1'b0;
      for (int step = 0; step < MAX_STEPS; step++) begin
         if (patch_after >= 0 && step >= patch_after && !visited[mpc]) rom[mpc] = HALT_WORD;
         visited[mpc] = 1'b1;
         ins = rom[mpc];
         op  = int'(ins[8:6]);
         sb.push_back('{ins, z, cnt, slot});
         cnt++;
         slot++;
         if (ins == HALT_WORD) begin
            halted      = 1'b1;
            final_count = cnt;
            final_zero  = z;
            return;
         end
         if (op <= 2) z = ^ins[5:0];
         if (op == 6 && z) begin
            off  = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
            mpc  = 8'(int'(mpc) + 1 + off);
            slot++;
         end else begin
            mpc = mpc + 8'd1;
         end
      end
   endtask

   task automatic fill_rom_random();
      for (int a = 0; a < 256; a++) rom[a] = 9'($urandom_range(511));
   endtask

   task automatic gen_random(output logic [7:0] start);
      bit ok;
      int tries;
      ok    = 1'b0;
      tries = 0;
      start = '0;
      while (!ok && tries < 50) begin
         sb.delete();
         fill_rom_random();
         start = 8'($urandom_range(255));
         model_run(start, RAND_LEN, ok);
         tries++;
      end
      if (!ok) begin
         $display("FAIL gen_random: no terminating program after %0d tries", tries);
         $fatal(1);
      end
   endtask

   task automatic launch(input logic [7:0] start);
      @(negedge CLK);
      ProgAddr = start;
      Go       = 1'b1;
      @(posedge CLK);
      #1;
      go_cyc = cyc;
      Go     = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_start"},      32'(Start), 32'd1);
      check({tag, "_start_addr"}, 32'(Start_Addr), 32'(ProgAddr));
      check({tag, "_dec_idle"},   32'(dec_active), 32'd0);
      check({tag, "_done"},       32'(Done), 32'd0);
      check({tag, "_count"},      32'(InstrCount), 32'd0);
      check({tag, "_zero"},       32'(Zero), 32'd0);
   endtask

   // Expectations must already be queued by model_run before this is called.
   task automatic run_program(input logic [7:0] start, input string tag);
      launch(start);
      @(negedge CLK);
      check({tag, "_fill_start"}, 32'(Start), 32'd0);
      check({tag, "_fill_idle"},  32'(dec_active), 32'd0);
      check({tag, "_fill_count"}, 32'(InstrCount), 32'd0);
      check({tag, "_fill_done"},  32'(Done), 32'd0);
      for (int c = 0; c < RUN_BUDGET && !Done; c++) begin
         @(negedge CLK);
         Go = 1'b0;
         if (!Done && $urandom_range(15) == 0) Go = 1'b1;
      end
      Go = 1'b0;
      check({tag, "_halt_reached"}, 32'(Done), 32'd1);
      check({tag, "_halt_start"},   32'(Start), 32'd1);
      check({tag, "_halt_addr"},    32'(Start_Addr), 32'(start));
      check({tag, "_halt_count"},   32'(InstrCount), 32'(final_count % (1 << CNT_W)));
      check({tag, "_halt_zero"},    32'(Zero), 32'(final_zero));
      check({tag, "_halt_dec"},     32'(dec_active), 32'd0);
      check({tag, "_sb_drained"},   32'(sb.size()), 32'd0);
      sb.delete();
      if (!Done) begin
         Reset = 1'b1;
         @(negedge CLK);
         Reset = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] s;
      bit         h;

      Reset    = 1'b1;
      Go       = 1'b1;
      ProgAddr = 8'd77;
      fill_rom_random();

      // Reset and Go together: reset must win and leave the block idle.
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_reset_state("por");
      Go    = 1'b0;
      Reset = 1'b0;
      @(negedge CLK);
      check_reset_state("idle");

      // Straight-line program at 10: seven instructions then HALT.
      rom[10] = 9'h14D;  // LI
      rom[11] = 9'h011;  // ADD
      rom[12] = 9'h0DA;  // LOAD
      rom[13] = 9'h119;  // STORE
      rom[14] = 9'h08A;  // AND
      rom[15] = 9'h049;  // SUB
      rom[16] = 9'h1C0;  // SYS NOP
      rom[17] = HALT_WORD;
      model_run(8'd10, -1, h);
      run_program(8'd10, "prog_a");
      model_run(8'd10, -1, h);
      run_program(8'd10, "prog_a_restart");

      // Branches: taken +4 from 20, not-taken at 26, taken -5 from 30, taken +8 from 26.
      fill_rom_random();
      rom[18] = 9'h14B;  // LI
      rom[19] = 9'h041;  // SUB, zero result
      rom[20] = 9'h184;  // BZ +4
      rom[21] = 9'h17F;  // wrong path
      rom[25] = 9'h01B;  // ADD, non-zero result
      rom[26] = 9'h188;  // BZ +8
      rom[27] = 9'h050;  // SUB, zero result
      rom[28] = 9'h111;  // STORE
      rom[29] = 9'h0CA;  // LOAD
      rom[30] = 9'h1BB;  // BZ -5
      rom[31] = 9'h0C0;  // wrong path
      rom[35] = HALT_WORD;
      model_run(8'd18, -1, h);
      run_program(8'd18, "prog_b");

      for (int n = 0; n < 12; n++) begin
         gen_random(s);
         run_program(s, "rand");
      end

      // Reset together with Go in the middle of a program.
      gen_random(s);
      launch(s);
      repeat (6) @(negedge CLK);
      Reset = 1'b1;
      Go    = 1'b1;
      @(posedge CLK);
      #1;
      sb.delete();
      Reset = 1'b0;
      Go    = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check_reset_state("midrun_reset");
      end

      gen_random(s);
      run_program(s, "after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
